// File: rtl/usb_ep_status_bus_if.sv
// ---------------------------------------------------------------------------
// usb_ep_status_bus_if
// Purpose : SoC register-bus side of the endpoint status RAM initiator.
//           Carries one single-word request and its completion.
// Signals :
//   bus_addr [9:0]  [7:0] word address, [9:8] op (00 plain, 01 set-bits,
//                   10 clear-bits, 11 reserved / read-as-zero)
//   bus_din  [15:0] write data, or bit mask for set/clear ops
//   bus_we          1 = write, 0 = read
//   bus_cyc         request, held with addr/din/we until bus_ack
//   bus_ack         one-cycle completion pulse
//   bus_dout [15:0] read data, valid only in the bus_ack cycle (0 otherwise)
// Handshake: the master raises bus_cyc with a stable request and keeps it
//   until it sees bus_ack high on a rising edge; it then drops bus_cyc.
//   The slave ignores bus_cyc in its ack cycle, so one request is never
//   taken twice.
// Modports: master = bus owner (SoC side), slave = this block.
// ---------------------------------------------------------------------------
interface usb_ep_status_bus_if;
  logic [9:0]  bus_addr;
  logic [15:0] bus_din;
  logic        bus_we;
  logic        bus_cyc;
  logic        bus_ack;
  logic [15:0] bus_dout;

  modport master (
    output bus_addr,
    output bus_din,
    output bus_we,
    output bus_cyc,
    input  bus_ack,
    input  bus_dout
  );

  modport slave (
    input  bus_addr,
    input  bus_din,
    input  bus_we,
    input  bus_cyc,
    output bus_ack,
    output bus_dout
  );
endinterface

// File: rtl/usb_ep_status_bus.sv
// ---------------------------------------------------------------------------
// usb_ep_status_bus
// Purpose : Bus-side initiator for the aux R/W port of the endpoint status
//           RAM (8-bit word address, 16-bit words). Converts single-word bus
//           reads/writes into aux strobes, honours aux back-pressure and the
//           fixed aux read latency, and provides bit-set / bit-clear
//           read-modify-write ops so software can flip single status flags
//           without reading back first. The USB transaction engine owns the
//           priority port; this block only uses the aux port.
// Parameters:
//   RD_LAT       cycles from an accepted aux read strobe to valid i_s_dout_3
// Ports:
//   clk, rst     clock; synchronous active-high reset
//   bus          usb_ep_status_bus_if.slave (request / completion)
//   o_busy       FSM not in IDLE
//   o_state      FSM state (debug visibility)
//   o_s_addr_0   aux address
//   o_s_read_0   aux read strobe
//   o_s_zero_0   aux read-as-zero strobe (op 11 reads)
//   o_s_write_0  aux write strobe
//   o_s_din_0    aux write data
//   i_s_dout_3   aux read data, valid RD_LAT cycles after acceptance
//   i_s_ready_0  aux strobe accepted this cycle when high
// Handshake: an aux strobe is a valid; it stays high with stable address and
//   data every cycle until i_s_ready_0 is high in the same cycle, which is
//   the cycle the RAM takes it. Bus side is cyc/ack as in the interface.
// Notes:
//   All aux strobes and bus outputs are registered from the next-state
//   decode, so they line up with the state they belong to. At most one of
//   read/zero/write is high in any cycle because each maps to one state/op.
//   The RMW is not atomic against the priority port: a priority write to
//   the same word between the read and write phases is overwritten.
// ---------------------------------------------------------------------------
module usb_ep_status_bus #(
  parameter int RD_LAT = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  usb_ep_status_bus_if.slave     bus,
  output logic                   o_busy,
  output logic [2:0]             o_state,
  output logic [7:0]             o_s_addr_0,
  output logic                   o_s_read_0,
  output logic                   o_s_zero_0,
  output logic                   o_s_write_0,
  output logic [15:0]            o_s_din_0,
  input  logic [15:0]            i_s_dout_3,
  input  logic                   i_s_ready_0
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_ISS  = 3'd1,
    S_RD_WAIT = 3'd2,
    S_WR_ISS  = 3'd3,
    S_ACK     = 3'd4
  } state_t;

  localparam logic [1:0] OP_PLAIN = 2'b00;
  localparam logic [1:0] OP_SET   = 2'b01;
  localparam logic [1:0] OP_CLR   = 2'b10;
  localparam logic [1:0] OP_ZERO  = 2'b11;

  // Countdown covers RD_LAT cycles: loaded with RD_LAT-1 on acceptance,
  // data is captured in the cycle it reads 0.
  localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(RD_LAT - 1);

  // Registered state and latched request
  state_t         r_state;
  logic [7:0]     r_addr;
  logic [15:0]    r_mask;
  logic           r_we;
  logic [1:0]     r_op;
  logic [CW-1:0]  r_cnt;
  logic [15:0]    r_data;

  // Registered outputs
  logic           r_s_read;
  logic           r_s_zero;
  logic           r_s_write;
  logic [7:0]     r_s_addr;
  logic [15:0]    r_s_din;
  logic           r_ack;
  logic [15:0]    r_dout;

  // Next-state values
  state_t         w_next;
  logic [7:0]     w_addr;
  logic [15:0]    w_mask;
  logic           w_we;
  logic [1:0]     w_op;
  logic [CW-1:0]  w_cnt;
  logic [15:0]    w_data;
  logic [15:0]    w_wdata;
  logic           w_issue;

  always_comb begin
    w_next  = r_state;
    w_addr  = r_addr;
    w_mask  = r_mask;
    w_we    = r_we;
    w_op    = r_op;
    w_cnt   = r_cnt;
    w_data  = r_data;
    w_wdata = r_s_din;

    case (r_state)
      S_IDLE: begin
        if (bus.bus_cyc) begin
          // Op bits are kept apart from the word address; they never
          // reach the RAM.
          w_addr = bus.bus_addr[7:0];
          w_op   = bus.bus_addr[9:8];
          w_mask = bus.bus_din;
          w_we   = bus.bus_we;
          if (!bus.bus_we) begin
            w_next = S_RD_ISS;
          end else begin
            case (bus.bus_addr[9:8])
              OP_PLAIN: begin
                w_wdata = bus.bus_din;
                w_next  = S_WR_ISS;
              end
              OP_SET, OP_CLR: w_next = S_RD_ISS;
              default:        w_next = S_ACK;  // reserved-op write is dropped
            endcase
          end
        end
      end

      S_RD_ISS: begin
        if (i_s_ready_0) begin
          w_next = S_RD_WAIT;
          w_cnt  = CNT_INIT;
        end
      end

      S_RD_WAIT: begin
        if (r_cnt == '0) begin
          w_data = i_s_dout_3;
          if (!r_we) begin
            w_next = S_ACK;
          end else begin
            w_next  = S_WR_ISS;
            w_wdata = (r_op == OP_SET) ? (i_s_dout_3 | r_mask)
                                       : (i_s_dout_3 & ~r_mask);
          end
        end else begin
          w_cnt = r_cnt - 1'b1;
        end
      end

      S_WR_ISS: begin
        if (i_s_ready_0) begin
          w_next = S_ACK;
        end
      end

      S_ACK: begin
        // bus_cyc is deliberately not looked at here.
        w_next = S_IDLE;
      end

      default: w_next = S_IDLE;
    endcase
  end

  assign w_issue = (w_next == S_RD_ISS) || (w_next == S_WR_ISS);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_addr    <= '0;
      r_mask    <= '0;
      r_we      <= 1'b0;
      r_op      <= OP_PLAIN;
      r_cnt     <= '0;
      r_data    <= '0;
      r_s_read  <= 1'b0;
      r_s_zero  <= 1'b0;
      r_s_write <= 1'b0;
      r_s_addr  <= '0;
      r_s_din   <= '0;
      r_ack     <= 1'b0;
      r_dout    <= '0;
    end else begin
      r_state   <= w_next;
      r_addr    <= w_addr;
      r_mask    <= w_mask;
      r_we      <= w_we;
      r_op      <= w_op;
      r_cnt     <= w_cnt;
      r_data    <= w_data;
      // Strobes follow the state they will be shown in next cycle, so a
      // stalled issue keeps its strobe up until the RAM takes it.
      r_s_read  <= (w_next == S_RD_ISS) && (w_op != OP_ZERO);
      r_s_zero  <= (w_next == S_RD_ISS) && (w_op == OP_ZERO);
      r_s_write <= (w_next == S_WR_ISS);
      r_s_addr  <= w_issue ? w_addr : r_s_addr;
      r_s_din   <= w_wdata;
      r_ack     <= (w_next == S_ACK);
      // Read data is only presented in the ack cycle; writes ack with 0.
      r_dout    <= ((w_next == S_ACK) && !w_we) ? w_data : 16'h0000;
    end
  end

  assign bus.bus_ack  = r_ack;
  assign bus.bus_dout = r_dout;
  assign o_busy       = (r_state != S_IDLE);
  assign o_state      = r_state;
  assign o_s_addr_0   = r_s_addr;
  assign o_s_read_0   = r_s_read;
  assign o_s_zero_0   = r_s_zero;
  assign o_s_write_0  = r_s_write;
  assign o_s_din_0    = r_s_din;

endmodule

// File: tb/tb_usb_ep_status_bus.sv
// ---------------------------------------------------------------------------
// tb_usb_ep_status_bus
// Directed bench for usb_ep_status_bus. A small aux RAM responder with
// fixed read latency and programmable back-pressure sits on the aux port.
// For each request a transaction-level model lays out the expected
// per-cycle output trace (strobes, address, data, ack, dout, busy) from the
// latency rules; one compare branch checks the DUT against it every cycle.
// Hand-computed literals pin ack timing, read data and RAM contents.
// ---------------------------------------------------------------------------
module tb_usb_ep_status_bus;
  localparam int RD_LAT = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT ----------------
  usb_ep_status_bus_if bus_if ();
  logic        busy;
  logic [2:0]  dbg_state;
  logic [7:0]  s_addr;
  logic        s_read, s_zero, s_write;
  logic [15:0] s_din, s_dout;
  logic        s_ready;

  usb_ep_status_bus #(.RD_LAT(RD_LAT)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus_if.slave),
    .o_busy      (busy),
    .o_state     (dbg_state),
    .o_s_addr_0  (s_addr),
    .o_s_read_0  (s_read),
    .o_s_zero_0  (s_zero),
    .o_s_write_0 (s_write),
    .o_s_din_0   (s_din),
    .i_s_dout_3  (s_dout),
    .i_s_ready_0 (s_ready)
  );

  // ---------------- aux RAM responder ----------------
  logic [15:0] ram [256] = '{default: 16'h0000};
  logic [15:0] pipe0 = 16'hDEAD, pipe1 = 16'hDEAD, pipe2 = 16'hDEAD;
  int          stall_used = 0;
  int          stall_lim  = 0;
  logic        strobe;

  assign strobe  = s_read | s_zero | s_write;
  assign s_ready = !(strobe && (stall_used < stall_lim));
  assign s_dout  = pipe2;

  always @(posedge clk) begin
    if (s_write && s_ready) ram[s_addr] <= s_din;
    if (s_read && s_ready)      pipe0 <= ram[s_addr];
    else if (s_zero && s_ready) pipe0 <= 16'h0000;
    else                        pipe0 <= 16'hDEAD;
    pipe1 <= pipe0;
    pipe2 <= pipe1;
    if (strobe && !s_ready) stall_used <= stall_used + 1;
  end

  // ---------------- scoreboard ----------------
  // Trace entry: {read, zero, write, addr[7:0], din[15:0], ack, dout[15:0], busy}
  logic [44:0] exp_q[$];
  logic [15:0] exp_ram [256];
  int          exp_ack_cyc;
  int          total = 0;
  int          bad   = 0;
  logic        cmp_en = 1'b0;
  logic        done   = 1'b0;

  function automatic logic [44:0] ent(input logic rd, input logic zr, input logic wr,
                                      input logic [7:0] a, input logic [15:0] d,
                                      input logic ack, input logic [15:0] dout,
                                      input logic bsy);
    return {rd, zr, wr, a, d, ack, dout, bsy};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic cmp_cycle();
    logic [44:0] e;
    logic [44:0] a;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 45'd0;
    a = {s_read, s_zero, s_write,
         (e[44] | e[43] | e[42]) ? s_addr : 8'h00,
         e[42] ? s_din : 16'h0000,
         bus_if.bus_ack, bus_if.bus_dout, busy};
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL cycle_trace t=%0t got=%h want=%h", $time, a, e);
    end
  endtask

  // Expected cycle-by-cycle outputs of one request, cycle 0 = cyc first seen.
  // A stall applies to the first issue of the request only.
  task automatic push_trace(input logic [9:0] addr, input logic [15:0] din,
                            input logic we, input int stall);
    logic [1:0]  op;
    logic [7:0]  a;
    logic [15:0] rd_val, wr_val;
    op = addr[9:8];
    a  = addr[7:0];
    exp_q.push_back(ent(0, 0, 0, 8'h0, 16'h0, 0, 16'h0, 0));
    if (we && op == 2'b00) begin
      for (int i = 0; i <= stall; i++) exp_q.push_back(ent(0, 0, 1, a, din, 0, 16'h0, 1));
      exp_ram[a] = din;
      exp_q.push_back(ent(0, 0, 0, 8'h0, 16'h0, 1, 16'h0, 1));
    end else if (we && op == 2'b11) begin
      exp_q.push_back(ent(0, 0, 0, 8'h0, 16'h0, 1, 16'h0, 1));
    end else begin
      rd_val = (op == 2'b11) ? 16'h0000 : exp_ram[a];
      for (int i = 0; i <= stall; i++)
        exp_q.push_back(ent(op != 2'b11, op == 2'b11, 0, a, 16'h0, 0, 16'h0, 1));
      for (int i = 0; i < RD_LAT; i++) exp_q.push_back(ent(0, 0, 0, 8'h0, 16'h0, 0, 16'h0, 1));
      if (we) begin
        wr_val = (op == 2'b01) ? (rd_val | din) : (rd_val & ~din);
        exp_q.push_back(ent(0, 0, 1, a, wr_val, 0, 16'h0, 1));
        exp_ram[a] = wr_val;
        exp_q.push_back(ent(0, 0, 0, 8'h0, 16'h0, 1, 16'h0, 1));
      end else begin
        exp_q.push_back(ent(0, 0, 0, 8'h0, 16'h0, 1, rd_val, 1));
      end
    end
    exp_ack_cyc = exp_q.size() - 1;
  endtask

  // ---------------- driver ----------------
  task automatic do_xact(input logic [9:0] addr, input logic [15:0] din, input logic we,
                         input int stall, output int ack_cyc, output logic [15:0] dout);
    @(posedge clk); #1;
    stall_lim = stall_used + stall;
    push_trace(addr, din, we, stall);
    bus_if.bus_addr = addr;
    bus_if.bus_din  = din;
    bus_if.bus_we   = we;
    bus_if.bus_cyc  = 1'b1;
    ack_cyc = -1;
    dout    = 16'h0000;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus_if.bus_ack) begin
        ack_cyc = k;
        dout    = bus_if.bus_dout;
        break;
      end
    end
    chk("ack_cycle_model", ack_cyc, exp_ack_cyc);
    if (ack_cyc < 0) exp_q.delete();
    @(posedge clk); #1;
    bus_if.bus_cyc = 1'b0;
  endtask

  // ---------------- main ----------------
  initial begin
    int          ac;
    logic [15:0] dv;
    logic [15:0] saved;
    bus_if.bus_addr = '0;
    bus_if.bus_din  = '0;
    bus_if.bus_we   = 1'b0;
    bus_if.bus_cyc  = 1'b0;
    for (int i = 0; i < 256; i++) exp_ram[i] = 16'h0000;

    fork
      begin : main_seq
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy",    busy,           0);
        chk("rst_ack",     bus_if.bus_ack, 0);
        chk("rst_dout",    bus_if.bus_dout, 0);
        chk("rst_strobes", {s_read, s_zero, s_write}, 0);
        chk("rst_s_addr",  s_addr,         0);
        chk("rst_s_din",   s_din,          0);
        rst    = 1'b0;
        cmp_en = 1'b1;

        // Plain write, then read back
        do_xact(10'h012, 16'hBEEF, 1'b1, 0, ac, dv);
        chk("wr_ack_cyc", ac, 2);
        chk("wr_ram12", ram[8'h12], 16'hBEEF);
        do_xact(10'h012, 16'h0000, 1'b0, 0, ac, dv);
        chk("rd_ack_cyc", ac, 5);
        chk("rd_dout", dv, 16'hBEEF);

        // Preload, then set / clear bits
        do_xact(10'h020, 16'h00F0, 1'b1, 0, ac, dv);
        do_xact(10'h005, 16'hFFFF, 1'b1, 0, ac, dv);
        do_xact(10'h120, 16'h0F01, 1'b1, 0, ac, dv);
        chk("set_ack_cyc", ac, 6);
        chk("set_ram20", ram[8'h20], 16'h0FF1);
        do_xact(10'h220, 16'h0010, 1'b1, 0, ac, dv);
        chk("clr_ram20", ram[8'h20], 16'h0FE1);

        // Read with ready low for 4 cycles
        do_xact(10'h020, 16'h0000, 1'b0, 4, ac, dv);
        chk("stall_rd_ack_cyc", ac, 9);
        chk("stall_rd_dout", dv, 16'h0FE1);

        // Reserved op: read-as-zero, and a dropped write
        do_xact(10'h305, 16'h0000, 1'b0, 0, ac, dv);
        chk("zero_rd_dout", dv, 16'h0000);
        do_xact(10'h305, 16'h1234, 1'b1, 0, ac, dv);
        chk("zero_wr_ack_cyc", ac, 1);
        chk("zero_wr_ram05", ram[8'h05], 16'hFFFF);

        // Top address, stalled write and stalled set
        do_xact(10'h0FF, 16'hA5A5, 1'b1, 2, ac, dv);
        chk("stall_wr_ack_cyc", ac, 4);
        do_xact(10'h1FF, 16'h0F0F, 1'b1, 1, ac, dv);
        chk("stall_set_ack_cyc", ac, 7);
        chk("stall_set_ramff", ram[8'hFF], 16'hAFAF);
        do_xact(10'h1FF, 16'h0000, 1'b0, 0, ac, dv);
        chk("set_op_read_dout", dv, 16'hAFAF);

        // Reset in the read-wait phase of a set-bits op
        @(posedge clk); #1;
        saved = exp_ram[8'h20];
        push_trace(10'h120, 16'h7000, 1'b1, 0);
        exp_ram[8'h20] = saved;
        while (exp_q.size() > 4) void'(exp_q.pop_back());
        bus_if.bus_addr = 10'h120;
        bus_if.bus_din  = 16'h7000;
        bus_if.bus_we   = 1'b1;
        bus_if.bus_cyc  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        bus_if.bus_cyc = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (8) @(posedge clk);
        chk("rst_mid_ram20", ram[8'h20], 16'h0FE1);
        do_xact(10'h020, 16'h0000, 1'b0, 0, ac, dv);
        chk("post_rst_ack_cyc", ac, 5);
        chk("post_rst_dout", dv, 16'h0FE1);

        repeat (3) @(posedge clk);
        chk("exp_q_drained", exp_q.size(), 0);
        done = 1'b1;
      end
      begin : compare
        wait (cmp_en);
        while (!done) begin
          @(negedge clk);
          if (!done) cmp_cycle();
        end
      end
    join

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
